pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline-stage register for the in-order 5-stage core.
- Generic successor to the fixed per-stage latch modules. It replaces the global 2-bit stall code with a per-stage valid/ready handshake, an optional 2-entry skid buffer and a synchronous flush.
- Any payload bundle (IF/ID, ID/EX, EX/MEM, MEM/WB) is packed into one bus.
- Control bits selected by a mask are forced to a bubble value whenever the stage holds no valid instruction.

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline-stage register with optional 2-entry skid and flush
module pipe_stage_reg #(
    parameter int              DW         = 64,
    parameter int              SKID       = 1,
    parameter logic [DW-1:0]   CTRL_MASK  = {DW{1'b1}},
    parameter logic [DW-1:0]   BUBBLE_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy
);

    // Occupancy doubles as the state encoding: number of entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [1:0] OCC_MAX = (SKID != 0) ? 2'd2 : 2'd1;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          accept;
    logic          drain;

    // Masked control bits take the bubble value, unmasked bits keep their last value.
    function automatic logic [DW-1:0] to_bubble(input logic [DW-1:0] v);
        return (v & ~CTRL_MASK) | (BUBBLE_VAL & CTRL_MASK);
    endfunction

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Ready: registered-only with skid; single-register mode passes out_ready through.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = (state_q != ST_SKID) & ~rst;
        end else begin
            in_ready = ((state_q == ST_EMPTY) | out_ready) & ~rst;
        end
    end

    // Next-state: flush wins over the handshake; otherwise move entries FIFO-style.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = to_bubble(main_q);
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept && (SKID != 0)) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        main_d  = to_bubble(main_q);
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = to_bubble(main_q);
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State register; reset leaves an empty bubble with unmasked bits zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL & CTRL_MASK;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Entry count must stay within the configured depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occupancy <= OCC_MAX);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed check of pipe_stage_reg (SKID=1 and SKID=0) against a FIFO model
module tb_pipe_stage_reg;

    localparam logic [7:0] MASK = 8'h0F;
    localparam logic [7:0] BUB  = 8'h00;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic       rdy1, vld1, rdy0, vld0;
    logic [7:0] dat1, dat0;
    logic [1:0] occ1, occ0;

    int checks = 0;
    int errors = 0;

    // Model per instance: index 1 = SKID=1, index 0 = SKID=0.
    logic [7:0] mbuf [2][2];
    int         mcnt [2];
    logic [7:0] mlast [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(8), .SKID(1), .CTRL_MASK(MASK), .BUBBLE_VAL(BUB)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DW(8), .SKID(0), .CTRL_MASK(MASK), .BUBBLE_VAL(BUB)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
        .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] bubble(input logic [7:0] v);
        return (v & ~MASK) | (BUB & MASK);
    endfunction

    function automatic logic exp_ready(input int i);
        if (rst) return 1'b0;
        if (i == 1) return mcnt[i] < 2;
        return (mcnt[i] == 0) || out_ready;
    endfunction

    function automatic logic [7:0] exp_data(input int i);
        return (mcnt[i] > 0) ? mbuf[i][0] : bubble(mlast[i]);
    endfunction

    task automatic model_step(input int i);
        logic acc, drn;
        if (rst) begin
            mcnt[i]  = 0;
            mlast[i] = 8'h00;
        end else begin
            acc = in_valid && exp_ready(i);
            drn = (mcnt[i] > 0) && out_ready;
            if (flush) begin
                mcnt[i] = 0;
            end else begin
                if (drn) begin
                    mbuf[i][0] = mbuf[i][1];
                    mcnt[i]--;
                end
                if (acc) begin
                    mbuf[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                end
                if (mcnt[i] > 0) mlast[i] = mbuf[i][0];
            end
        end
    endtask

    task automatic check_model();
        check("s1_ready", {31'd0, rdy1}, {31'd0, exp_ready(1)});
        check("s1_valid", {31'd0, vld1}, {31'd0, mcnt[1] > 0});
        check("s1_data",  {24'd0, dat1}, {24'd0, exp_data(1)});
        check("s1_occ",   {30'd0, occ1}, mcnt[1]);
        check("s0_ready", {31'd0, rdy0}, {31'd0, exp_ready(0)});
        check("s0_valid", {31'd0, vld0}, {31'd0, mcnt[0] > 0});
        check("s0_data",  {24'd0, dat0}, {24'd0, exp_data(0)});
        check("s0_occ",   {30'd0, occ0}, mcnt[0]);
    endtask

    // Drive one cycle of inputs, check both outputs, step the model, land just after the next negedge.
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [7:0] id, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        check_model();
        @(posedge clk);
        model_step(1);
        model_step(0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0; mlast[0] = 8'h00; mlast[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            mbuf[i][0] = 8'h00;
            mbuf[i][1] = 8'h00;
        end
        @(negedge clk);
        #1;

        // Reset held two cycles with traffic offered.
        cyc(1, 0, 1, 8'hAB, 0);
        cyc(1, 0, 1, 8'hAB, 0);
        check("rst_valid", {31'd0, vld1}, 0);
        check("rst_data",  {24'd0, dat1}, 32'h00);
        check("rst_occ",   {30'd0, occ1}, 0);

        // Streaming.
        cyc(0, 0, 1, 8'h11, 1);
        check("stream_11", {24'd0, dat1}, 32'h11);
        cyc(0, 0, 1, 8'h22, 1);
        check("stream_22", {24'd0, dat1}, 32'h22);
        check("stream_occ", {30'd0, occ1}, 1);
        cyc(0, 0, 1, 8'h33, 1);
        check("stream_33", {24'd0, dat1}, 32'h33);
        cyc(0, 0, 0, 8'h00, 1);
        check("stream_empty", {31'd0, vld1}, 0);

        // Back-pressure into the skid entry.
        cyc(0, 0, 1, 8'h11, 1);
        cyc(0, 0, 1, 8'h22, 0);
        check("skid_occ2", {30'd0, occ1}, 2);
        check("skid_hold11", {24'd0, dat1}, 32'h11);
        cyc(0, 0, 1, 8'h33, 0);
        check("skid_rdy0", {31'd0, rdy1}, 0);
        check("skid_still11", {24'd0, dat1}, 32'h11);
        cyc(0, 0, 0, 8'h00, 1);
        check("skid_out22", {24'd0, dat1}, 32'h22);
        cyc(0, 0, 1, 8'h33, 1);
        check("skid_out33", {24'd0, dat1}, 32'h33);
        cyc(0, 0, 0, 8'h00, 1);

        // Drain to bubble.
        cyc(0, 0, 1, 8'hA5, 0);
        cyc(0, 0, 0, 8'h00, 1);
        check("bubble_valid", {31'd0, vld1}, 0);
        check("bubble_data",  {24'd0, dat1}, 32'hA0);

        // Flush a full skid stage while offering a payload.
        cyc(0, 0, 1, 8'h5C, 0);
        cyc(0, 0, 1, 8'h6D, 0);
        check("flush_pre_occ", {30'd0, occ1}, 2);
        cyc(0, 1, 1, 8'h7E, 0);
        check("flush_occ",   {30'd0, occ1}, 0);
        check("flush_valid", {31'd0, vld1}, 0);
        check("flush_data",  {24'd0, dat1}, 32'h50);
        cyc(0, 0, 0, 8'h00, 1);
        check("flush_no7e", {24'd0, dat1}, 32'h50);

        // Single-register mode: ready follows out_ready, replace without bubble.
        cyc(0, 0, 1, 8'h91, 1);
        check("s0_hold91", {24'd0, dat0}, 32'h91);
        cyc(0, 0, 1, 8'h92, 0);
        check("s0_blocked", {24'd0, dat0}, 32'h91);
        cyc(0, 0, 1, 8'h93, 1);
        check("s0_replace", {24'd0, dat0}, 32'h93);
        check("s0_novalid_gap", {31'd0, vld0}, 1);
        check("s0_occ1", {30'd0, occ0}, 1);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0),
                8'($urandom),
                ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
